// File: rtl/fetch_decode_buffer_pkg.sv
// Shared core definitions for the fetch-to-decode buffer: default sizing and
// the 64-bit entry layout {pc, instr}.
package fetch_decode_buffer_pkg;

  localparam int FDB_DEPTH = 8;
  localparam int FDB_SKID  = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fdb_entry_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-word stream with active-high stop backpressure: master drives the
// word, slave drives readyn.
interface fetch_decode_buffer_if;

  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        readyn;

  modport master (output valid, output pc, output instr, input readyn);
  modport slave  (input valid, input pc, input instr, output readyn);

endinterface

// File: rtl/fetch_decode_buffer_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port,
// read data available in the same cycle as the address; contents never reset.
module fetch_decode_buffer_ram
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = FDB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  fdb_entry_t       i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output fdb_entry_t       o_rdata
);

  fdb_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Circular fetch->decode FIFO; a push shows at the head one cycle later (no bypass).
// Fetch is stopped early (o_readyn) leaving SKID slots; pushes arriving when full are dropped and flagged.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int DEPTH = FDB_DEPTH,
  parameter int SKID  = FDB_SKID
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          snoop_hit,
  input  logic                          bco_valid,
  fetch_decode_buffer_if.slave          i_fetch,
  fetch_decode_buffer_if.master         o_decode,
  output logic                          o_overflow
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]    C_THR     = (AW+1)'(DEPTH - SKID);
  localparam logic [AW:0]    C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]  C_PTR_ONE = AW'(1);

  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_flush;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_we;
  fdb_entry_t    w_wdata;
  fdb_entry_t    w_rdata;

  assign w_flush = snoop_hit | bco_valid;
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = (r_count != '0) && !o_decode.readyn;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_push  = i_fetch.valid && (!w_full || w_pop);
  assign w_drop  = i_fetch.valid && w_full && !w_pop;
  assign w_we    = w_push && !w_flush && !reset;
  assign w_wdata = '{pc: i_fetch.pc, instr: i_fetch.instr};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - C_CNT_ONE;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  fetch_decode_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Backpressure depends on registered occupancy only, keeping decode off the fetch stop path.
  assign i_fetch.readyn = (r_count >= C_THR);
  assign o_decode.valid = (r_count != '0);
  assign o_decode.pc    = w_rdata.pc;
  assign o_decode.instr = w_rdata.instr;
  assign o_overflow     = r_overflow;

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count; it must be a power of two and at least 4.
REQ-003 Parameter SKID, default 3, SHALL set the in-flight fetch words tolerated after o_readyn asserts.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 snoop_hit  in  1  pipeline flush request.
REQ-007 bco_valid  in  1  branch-correction flush request.
REQ-008 i_valid  in  1  fetch word valid.
REQ-009 i_pc  in  32  fetch word PC.
REQ-010 i_instr  in  32  fetch word instruction.
REQ-011 o_readyn  out  1  backpressure to fetch; 1 = stop issuing.
REQ-012 o_valid  out  1  head entry valid toward decode.
REQ-013 o_pc  out  32  head entry PC.
REQ-014 o_instr  out  32  head entry instruction.
REQ-015 i_readyn  in  1  decode backpressure; 1 = decode not accepting.
REQ-016 o_overflow  out  1  sticky error flag; set when a push is dropped.

Function
REQ-017 The block SHALL be a circular FIFO with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1.
REQ-018 Push: i_valid=1 and the buffer not full (count<DEPTH), or full with a pop in the same cycle, SHALL write {i_pc,i_instr} at wptr and advance wptr.
REQ-019 Pop: o_valid=1 and i_readyn=0 SHALL advance rptr.
REQ-020 o_valid SHALL equal (count!=0), and o_pc/o_instr SHALL present the entry at rptr, with no bypass: a push into an empty buffer becomes visible the next cycle (latency 1).
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH and count=1.
REQ-022 o_readyn SHALL equal (count >= DEPTH-SKID), combinational from registered count only, never from i_readyn.
REQ-023 A push with count=DEPTH and no same-cycle pop SHALL be dropped and SHALL set o_overflow, which holds until reset.
REQ-024 snoop_hit=1 or bco_valid=1 SHALL clear count and both pointers at the next edge, discard any same-cycle push and pop, and leave o_overflow unchanged.
REQ-025 The flush SHALL take priority over push/pop, and reset SHALL take priority over the flush.
REQ-026 Entry storage SHALL not require reset; only pointers, count and o_overflow SHALL be reset.

Reset
REQ-027 On reset=1 at an edge: count=0, rptr=wptr=0, o_overflow=0.
REQ-028 Outputs after reset: o_valid=0, o_readyn=0, o_overflow=0; o_pc/o_instr are don't-care while o_valid=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries, and the same-cycle push SHALL be ignored.

Structure
REQ-030 DEPTH/SKID defaults and the 64-bit entry layout {pc[63:32], instr[31:0]} SHALL live in the shared core package.
REQ-031 One sub-module is natural: fetch_decode_buffer_ram (DEPTH x 64, one write port, one asynchronous read port); control stays in the top module.

Verification
REQ-032 Reset, then push 3 words (PC 0x100/0x104/0x108) with i_readyn=1 -> count=3, o_readyn=0; with i_readyn=0, decode receives 0x100, 0x104, 0x108 in order on consecutive cycles.
REQ-033 i_readyn=1, push 5 words -> o_readyn=1 in the cycle after the 5th push; 3 further pushes are accepted (count=8), o_overflow=0.
REQ-034 At count=8, push plus pop in one cycle -> count stays 8, the new word is stored at the wrapped wptr, and read order is preserved across the wrap.
REQ-035 At count=8, i_readyn=1, push 1 more -> word dropped, o_overflow=1 and held through a later flush, cleared only by reset.
REQ-036 At count=5, bco_valid=1 with i_valid=1 (PC 0x200) -> next cycle count=0, o_valid=0, o_readyn=0; 0x200 is never delivered.
REQ-037 Reset=1 asserted in a push+pop cycle at count=4 -> next cycle count=0, o_valid=0, o_overflow=0.
